// File: rtl/load_store_unit_pkg.sv
// Shared types and lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    WB     = 2'd3
  } lsu_state_t;

  localparam logic [3:0] BYTEEN_ALL = 4'b1111;

  function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
    case (lane)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      2'd3:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      2'd3:    return word[31:24];
      default: return 8'h00;
    endcase
  endfunction

  // ARMv4 unaligned word load: rotate right by whole bytes.
  function automatic logic [31:0] rotr_bytes(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word;
      2'd1:    return {word[7:0], word[31:8]};
      2'd2:    return {word[15:0], word[31:16]};
      2'd3:    return {word[23:0], word[31:24]};
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Datapath/memory bundle of the load/store unit; slave = the unit, master = its environment.
interface load_store_unit_if #(
  parameter int MEM_AW = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_load;
  logic              req_byte;
  logic [31:0]       req_addr;
  logic [31:0]       req_str_data;
  logic [3:0]        req_rd;
  logic              busy;
  logic [31:0]       w_data_ldr;
  logic [3:0]        w_addr_ldr;
  logic              w_en_ldr;
  logic              align_fault;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_byteen;
  logic              mem_wren;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_is_load, req_byte, req_addr, req_str_data, req_rd, mem_rdata,
    output req_ready, busy, w_data_ldr, w_addr_ldr, w_en_ldr, align_fault,
           mem_addr, mem_wdata, mem_byteen, mem_wren
  );

  modport master (
    output req_valid, req_is_load, req_byte, req_addr, req_str_data, req_rd, mem_rdata,
    input  req_ready, busy, w_data_ldr, w_addr_ldr, w_en_ldr, align_fault,
           mem_addr, mem_wdata, mem_byteen, mem_wren
  );
endinterface

// File: rtl/load_store_unit_byte_format.sv
// Combinational lane steering: store byte enables/replicated data and load result formatting.
module lsu_byte_format
  import lsu_pkg::*;
(
  input  logic        byte_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  // Byte accesses use a single lane; word accesses ignore or rotate by the low address bits.
  always_comb begin
    byteen_o  = BYTEEN_ALL;
    wdata_o   = st_data_i;
    ld_data_o = rdata_i;
    if (byte_i) begin
      byteen_o  = lane_onehot(lane_i);
      wdata_o   = {4{st_data_i[7:0]}};
      ld_data_o = {24'h00_0000, lane_byte(rdata_i, lane_i)};
    end else begin
      byteen_o  = BYTEEN_ALL;
      wdata_o   = st_data_i;
      ld_data_o = rotr_bytes(rdata_i, lane_i);
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding access on a synchronous data RAM; loads are written back to the regfile.
// Optional build macro LSU_ALIGN_CHECK_EN: misaligned word requests raise align_fault instead of accessing RAM.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW  = 11,
  parameter int MEM_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  lsu_state_t        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        lane_q, lane_d;
  logic [3:0]        rd_q, rd_d;
  logic              is_load_q, is_load_d;
  logic              byte_q, byte_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [MEM_AW-1:0] maddr_q, maddr_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic [3:0]        byteen_q, byteen_d;
  logic              wren_q, wren_d;
  logic [31:0]       ldr_data_q, ldr_data_d;
  logic [3:0]        ldr_addr_q, ldr_addr_d;
  logic              ldr_en_q, ldr_en_d;
  logic              fault_q, fault_d;

  logic              misalign_s;
  logic              fmt_byte_s;
  logic [1:0]        fmt_lane_s;
  logic [3:0]        fmt_byteen_s;
  logic [31:0]       fmt_wdata_s;
  logic [31:0]       fmt_ld_s;

`ifdef LSU_ALIGN_CHECK_EN
  assign misalign_s = !bus.req_byte && (bus.req_addr[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  // Stores are formatted from the live request at accept; loads from the latched request.
  assign fmt_byte_s = (state_q == IDLE) ? bus.req_byte      : byte_q;
  assign fmt_lane_s = (state_q == IDLE) ? bus.req_addr[1:0] : lane_q;

  lsu_byte_format u_fmt (
    .byte_i    (fmt_byte_s),
    .lane_i    (fmt_lane_s),
    .st_data_i (bus.req_str_data),
    .rdata_i   (bus.mem_rdata),
    .byteen_o  (fmt_byteen_s),
    .wdata_o   (fmt_wdata_s),
    .ld_data_o (fmt_ld_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the WAIT exit is the cycle the RAM data is valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) state_d = ACCESS;
        else               state_d = IDLE;
      end
      ACCESS: begin
        if (fault_q || !is_load_q) state_d = IDLE;
        else                       state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 3'd1) state_d = WB;
        else               state_d = WAIT;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the request latches, wait counter and registered outputs.
  always_comb begin
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    rd_d       = rd_q;
    is_load_d  = is_load_q;
    byte_d     = byte_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
    byteen_d   = 4'b0000;
    wren_d     = 1'b0;
    fault_d    = 1'b0;
    ldr_data_d = ldr_data_q;
    ldr_addr_d = ldr_addr_q;
    ldr_en_d   = 1'b0;
    ready_d    = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          lane_d    = bus.req_addr[1:0];
          rd_d      = bus.req_rd;
          is_load_d = bus.req_is_load;
          byte_d    = bus.req_byte;
          maddr_d   = bus.req_addr[MEM_AW+1:2];
          if (misalign_s) begin
            fault_d = 1'b1;
          end else if (!bus.req_is_load) begin
            wren_d   = 1'b1;
            byteen_d = fmt_byteen_s;
            mwdata_d = fmt_wdata_s;
          end else begin
            wren_d = 1'b0;
          end
        end else begin
          lane_d = lane_q;
        end
      end
      ACCESS: cnt_d = LAT_INIT;
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          ldr_data_d = fmt_ld_s;
          ldr_addr_d = rd_q;
          ldr_en_d   = 1'b1;
        end else begin
          ldr_en_d = 1'b0;
        end
      end
      WB:      cnt_d = 3'd0;
      default: cnt_d = 3'd0;
    endcase
  end

  // Request latches and output registers; reset clears mem_wren without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 3'd0;
      lane_q     <= 2'd0;
      rd_q       <= 4'd0;
      is_load_q  <= 1'b0;
      byte_q     <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      maddr_q    <= '0;
      mwdata_q   <= 32'h0000_0000;
      byteen_q   <= 4'b0000;
      wren_q     <= 1'b0;
      ldr_data_q <= 32'h0000_0000;
      ldr_addr_q <= 4'd0;
      ldr_en_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lane_q     <= lane_d;
      rd_q       <= rd_d;
      is_load_q  <= is_load_d;
      byte_q     <= byte_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      maddr_q    <= maddr_d;
      mwdata_q   <= mwdata_d;
      byteen_q   <= byteen_d;
      wren_q     <= wren_d;
      ldr_data_q <= ldr_data_d;
      ldr_addr_q <= ldr_addr_d;
      ldr_en_q   <= ldr_en_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.busy        = busy_q;
  assign bus.mem_addr    = maddr_q;
  assign bus.mem_wdata   = mwdata_q;
  assign bus.mem_byteen  = byteen_q;
  assign bus.mem_wren    = wren_q;
  assign bus.w_data_ldr  = ldr_data_q;
  assign bus.w_addr_ldr  = ldr_addr_q;
  assign bus.w_en_ldr    = ldr_en_q;
  assign bus.align_fault = fault_q;

endmodule
